ram_sp_be_clr: RTL and testbench

Parametrised single-port SRAM block with column (byte) write masks, optional output register stage and a hardware clear engine.
- The clear engine fills every word with a constant after reset or on request.
- Read data carries a valid strobe and is held between reads.
- Intended as the generic successor to the fixed-size single-port buffers in the encoder's mem/ directory, e.g. for line buffers and context stores that need a known initial state.

---
 rtl/ram_sp_be_clr_pkg.sv | 14 +
 rtl/ram_sp_be_core.sv | 39 +++
 rtl/ram_sp_be_clr.sv | 124 ++++++++++++
 tb/tb_ram_sp_be_clr.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_sp_be_clr_pkg.sv
// Shared types and helpers for the single-port byte-masked RAM with clear engine.
package ram_sp_be_clr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CLR  = 1'b1
  } state_t;

  // Number of write-mask columns in a data word
  function automatic int unsigned msk_wd(input int unsigned dat_wd, input int unsigned col_wd);
    return dat_wd / col_wd;
  endfunction

endpackage

// File: rtl/ram_sp_be_core.sv
// Raw storage array: column-masked write, one-cycle registered read port.
module ram_sp_be_core
  import ram_sp_be_clr_pkg::*;
#(
  parameter int unsigned ADR_WD = 8,
  parameter int unsigned DAT_WD = 32,
  parameter int unsigned COL_WD = 8,
  localparam int unsigned MSK_WD = msk_wd(DAT_WD, COL_WD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_ena,
  input  logic              rd_ena,
  input  logic [ADR_WD-1:0] adr,
  input  logic [MSK_WD-1:0] msk,
  input  logic [DAT_WD-1:0] dat,
  output logic [DAT_WD-1:0] q
);

  localparam int unsigned DEPTH = 2 ** ADR_WD;

  logic [DAT_WD-1:0] mem [DEPTH];

  // Array itself is never reset; only enabled columns are touched
  always_ff @(posedge clk) begin
    if (wr_ena) begin
      for (int unsigned k = 0; k < MSK_WD; k++) begin
        if (msk[k]) mem[adr][k*COL_WD +: COL_WD] <= dat[k*COL_WD +: COL_WD];
      end
    end
  end

  // Read register holds its value between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (rd_ena) q <= mem[adr];
  end

endmodule

// File: rtl/ram_sp_be_clr.sv
// Single-port RAM with byte write masks, optional output register and a
// hardware clear engine that fills every word with CLR_VAL.
module ram_sp_be_clr
  import ram_sp_be_clr_pkg::*;
#(
  parameter int unsigned        ADR_WD     = 8,
  parameter int unsigned        DAT_WD     = 32,
  parameter int unsigned        COL_WD     = 8,
  parameter bit                 OUT_REG    = 1'b0,
  parameter bit                 CLR_ON_RST = 1'b1,
  parameter logic [DAT_WD-1:0]  CLR_VAL    = '0,
  localparam int unsigned       MSK_WD     = msk_wd(DAT_WD, COL_WD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  output logic              busy_o,
  input  logic [ADR_WD-1:0] adr_i,
  input  logic              wr_ena_i,
  input  logic [MSK_WD-1:0] wr_msk_i,
  input  logic [DAT_WD-1:0] wr_dat_i,
  input  logic              rd_ena_i,
  output logic [DAT_WD-1:0] rd_dat_o,
  output logic              rd_val_o
);

  localparam logic [ADR_WD:0] LAST = (ADR_WD+1)'((2 ** ADR_WD) - 1);

  state_t            state, state_nxt;
  logic [ADR_WD:0]   cnt, cnt_nxt;
  logic              pend;
  logic              idle;
  logic              wr_acc, rd_acc;
  logic              core_wr;
  logic [ADR_WD-1:0] core_adr;
  logic [MSK_WD-1:0] core_msk;
  logic [DAT_WD-1:0] core_dat;
  logic [DAT_WD-1:0] core_q;
  logic              rd_v1;

  // pend requests the automatic clear on the first clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      pend   <= CLR_ON_RST;
      busy_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      pend   <= 1'b0;
      busy_o <= (state_nxt == CLR);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (pend || clr_i) state_nxt = CLR;
      end
      CLR: begin
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + (ADR_WD+1)'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // User port is only honoured while idle; a write wins over a read
  assign idle   = (state == IDLE);
  assign wr_acc = idle & wr_ena_i;
  assign rd_acc = idle & rd_ena_i & ~wr_ena_i;

  assign core_wr  = !idle | wr_acc;
  assign core_adr = idle ? adr_i    : cnt[ADR_WD-1:0];
  assign core_msk = idle ? wr_msk_i : '1;
  assign core_dat = idle ? wr_dat_i : CLR_VAL;

  ram_sp_be_core #(
    .ADR_WD (ADR_WD),
    .DAT_WD (DAT_WD),
    .COL_WD (COL_WD)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_ena (core_wr),
    .rd_ena (rd_acc),
    .adr    (core_adr),
    .msk    (core_msk),
    .dat    (core_dat),
    .q      (core_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_v1 <= 1'b0;
    else        rd_v1 <= rd_acc;
  end

  generate
    if (OUT_REG) begin : g_out_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_val_o <= 1'b0;
          rd_dat_o <= '0;
        end else begin
          rd_val_o <= rd_v1;
          if (rd_v1) rd_dat_o <= core_q;
        end
      end
    end else begin : g_out_direct
      // Core read register already holds data between reads
      assign rd_val_o = rd_v1;
      assign rd_dat_o = core_q;
    end
  endgenerate

endmodule

// File: tb/tb_ram_sp_be_clr.sv
// Directed bench: two instances (OUT_REG=0 with CLR_VAL=0, OUT_REG=1 with a
// non-zero CLR_VAL) share one stimulus stream.
module tb_ram_sp_be_clr;

  localparam logic [31:0] CLR1 = 32'hA5C3_0F96;

  logic        clk, rst_n, clr, wr_ena, rd_ena;
  logic [7:0]  adr;
  logic [3:0]  msk;
  logic [31:0] wdat;
  logic        busy0, busy1, rd_val0, rd_val1;
  logic [31:0] rd_dat0, rd_dat1;

  int n_chk  = 0;
  int n_pass = 0;

  ram_sp_be_clr dut0 (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .busy_o(busy0), .adr_i(adr),
    .wr_ena_i(wr_ena), .wr_msk_i(msk), .wr_dat_i(wdat), .rd_ena_i(rd_ena),
    .rd_dat_o(rd_dat0), .rd_val_o(rd_val0)
  );

  ram_sp_be_clr #(.OUT_REG(1'b1), .CLR_VAL(CLR1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .busy_o(busy1), .adr_i(adr),
    .wr_ena_i(wr_ena), .wr_msk_i(msk), .wr_dat_i(wdat), .rd_ena_i(rd_ena),
    .rd_dat_o(rd_dat1), .rd_val_o(rd_val1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts busy cycles of both instances until both are low again
  task automatic measure_busy(output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy0) n0++;
      if (busy1) n1++;
      if ((n0 > 0 || n1 > 0) && !busy0 && !busy1) break;
    end
  endtask

  task automatic test_reset;
    int n0, n1;
    repeat (3) @(negedge clk);
    n_chk++; if (busy0 !== 1'b0) $display("FAIL rst_busy0 got %b exp 0", busy0); else n_pass++;
    n_chk++; if (busy1 !== 1'b0) $display("FAIL rst_busy1 got %b exp 0", busy1); else n_pass++;
    n_chk++; if (rd_val0 !== 1'b0) $display("FAIL rst_val0 got %b exp 0", rd_val0); else n_pass++;
    n_chk++; if (rd_val1 !== 1'b0) $display("FAIL rst_val1 got %b exp 0", rd_val1); else n_pass++;
    n_chk++; if (rd_dat0 !== 32'h0) $display("FAIL rst_dat0 got %h exp 0", rd_dat0); else n_pass++;
    n_chk++; if (rd_dat1 !== 32'h0) $display("FAIL rst_dat1 got %h exp 0", rd_dat1); else n_pass++;
    rst_n = 1'b1;
    measure_busy(n0, n1);
    n_chk++; if (n0 != 256) $display("FAIL rst_clr_len0 got %0d exp 256", n0); else n_pass++;
    n_chk++; if (n1 != 256) $display("FAIL rst_clr_len1 got %0d exp 256", n1); else n_pass++;
  endtask

  task automatic test_clear_read;
    adr = 8'hFF; rd_ena = 1'b1;
    @(negedge clk); rd_ena = 1'b0;
    n_chk++; if (rd_val0 !== 1'b1) $display("FAIL clr_rd_val0 got %b exp 1", rd_val0); else n_pass++;
    n_chk++; if (rd_dat0 !== 32'h0) $display("FAIL clr_rd_dat0 got %h exp 0", rd_dat0); else n_pass++;
    n_chk++; if (rd_val1 !== 1'b0) $display("FAIL clr_rd_val1_early got %b exp 0", rd_val1); else n_pass++;
    @(negedge clk);
    n_chk++; if (rd_val1 !== 1'b1) $display("FAIL clr_rd_val1 got %b exp 1", rd_val1); else n_pass++;
    n_chk++; if (rd_dat1 !== CLR1) $display("FAIL clr_rd_dat1 got %h exp %h", rd_dat1, CLR1); else n_pass++;
    n_chk++; if (rd_val0 !== 1'b0) $display("FAIL clr_rd_val0_late got %b exp 0", rd_val0); else n_pass++;
  endtask

  task automatic test_masked_write;
    adr = 8'h12; wr_ena = 1'b1; msk = 4'b1111; wdat = 32'hDEAD_BEEF;
    @(negedge clk); msk = 4'b0000; wdat = 32'h0000_0000;
    @(negedge clk); msk = 4'b0101; wdat = 32'h1122_3344;
    @(negedge clk); wr_ena = 1'b0; rd_ena = 1'b1;
    @(negedge clk); rd_ena = 1'b0;
    n_chk++; if (rd_val0 !== 1'b1) $display("FAIL mask_val0 got %b exp 1", rd_val0); else n_pass++;
    n_chk++; if (rd_dat0 !== 32'hDE22_BE44) $display("FAIL mask_dat0 got %h exp de22be44", rd_dat0); else n_pass++;
    @(negedge clk);
    n_chk++; if (rd_val1 !== 1'b1) $display("FAIL mask_val1 got %b exp 1", rd_val1); else n_pass++;
    n_chk++; if (rd_dat1 !== 32'hDE22_BE44) $display("FAIL mask_dat1 got %h exp de22be44", rd_dat1); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] d [3];
    logic [31:0] ed0, ed1;
    logic        ev0, ev1;
    d[0] = 32'h0101_A0B1; d[1] = 32'h0202_C0D2; d[2] = 32'h0303_E0F3;
    wr_ena = 1'b1; msk = 4'hF;
    for (int i = 0; i < 3; i++) begin
      adr = 8'(i + 1); wdat = d[i];
      @(negedge clk);
    end
    wr_ena = 1'b0;
    ed0 = 32'hDE22_BE44; ed1 = 32'hDE22_BE44;
    for (int k = 0; k < 7; k++) begin
      rd_ena = (k < 3); adr = 8'(k + 1);
      @(negedge clk);
      ev0 = (k <= 2);
      ev1 = (k >= 1 && k <= 3);
      if (ev0) ed0 = d[k];
      if (ev1) ed1 = d[k-1];
      n_chk++; if (rd_val0 !== ev0) $display("FAIL b2b_val0[%0d] got %b exp %b", k, rd_val0, ev0); else n_pass++;
      n_chk++; if (rd_dat0 !== ed0) $display("FAIL b2b_dat0[%0d] got %h exp %h", k, rd_dat0, ed0); else n_pass++;
      n_chk++; if (rd_val1 !== ev1) $display("FAIL b2b_val1[%0d] got %b exp %b", k, rd_val1, ev1); else n_pass++;
      n_chk++; if (rd_dat1 !== ed1) $display("FAIL b2b_dat1[%0d] got %h exp %h", k, rd_dat1, ed1); else n_pass++;
    end
    rd_ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_chk++; if (rd_val1 !== 1'b0) $display("FAIL hold_val1[%0d] got %b exp 0", k, rd_val1); else n_pass++;
    end
    n_chk++; if (rd_dat1 !== d[2]) $display("FAIL hold_dat1 got %h exp %h", rd_dat1, d[2]); else n_pass++;
    n_chk++; if (rd_dat0 !== d[2]) $display("FAIL hold_dat0 got %h exp %h", rd_dat0, d[2]); else n_pass++;
  endtask

  task automatic test_wr_rd_collision;
    adr = 8'h20; wdat = 32'h5A5A_5A5A; msk = 4'hF; wr_ena = 1'b1; rd_ena = 1'b1;
    @(negedge clk); wr_ena = 1'b0; rd_ena = 1'b0;
    n_chk++; if (rd_val0 !== 1'b0) $display("FAIL coll_val0 got %b exp 0", rd_val0); else n_pass++;
    @(negedge clk);
    n_chk++; if (rd_val1 !== 1'b0) $display("FAIL coll_val1 got %b exp 0", rd_val1); else n_pass++;
    n_chk++; if (rd_dat0 !== 32'h0303_E0F3) $display("FAIL coll_hold0 got %h exp 0303e0f3", rd_dat0); else n_pass++;
    rd_ena = 1'b1;
    @(negedge clk); rd_ena = 1'b0;
    n_chk++; if (rd_dat0 !== 32'h5A5A_5A5A || rd_val0 !== 1'b1) $display("FAIL coll_rd0 got %h/%b exp 5a5a5a5a/1", rd_dat0, rd_val0); else n_pass++;
    @(negedge clk);
    n_chk++; if (rd_dat1 !== 32'h5A5A_5A5A || rd_val1 !== 1'b1) $display("FAIL coll_rd1 got %h/%b exp 5a5a5a5a/1", rd_dat1, rd_val1); else n_pass++;
  endtask

  task automatic test_busy_ignore;
    int n0, n1, seen;
    adr = 8'h05; wdat = 32'h1234_5678; msk = 4'hF; wr_ena = 1'b1;
    @(negedge clk); wr_ena = 1'b0; clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    n0 = 0; n1 = 0; seen = 0;
    for (int i = 0; i < 2000; i++) begin
      if (busy0) n0++;
      if (busy1) n1++;
      if (rd_val0 || rd_val1) seen++;
      if (!busy0 && !busy1) break;
      clr = (n0 == 10); wr_ena = (n0 == 10); rd_ena = (n0 == 20);
      adr = 8'h05; wdat = 32'hFFFF_FFFF; msk = 4'hF;
      @(negedge clk);
    end
    clr = 1'b0; wr_ena = 1'b0; rd_ena = 1'b0;
    n_chk++; if (n0 != 256) $display("FAIL busy_len0 got %0d exp 256", n0); else n_pass++;
    n_chk++; if (n1 != 256) $display("FAIL busy_len1 got %0d exp 256", n1); else n_pass++;
    n_chk++; if (seen != 0) $display("FAIL busy_rd_val got %0d exp 0", seen); else n_pass++;
    rd_ena = 1'b1;
    @(negedge clk); rd_ena = 1'b0;
    n_chk++; if (rd_dat0 !== 32'h0 || rd_val0 !== 1'b1) $display("FAIL busy_rd0 got %h/%b exp 0/1", rd_dat0, rd_val0); else n_pass++;
    @(negedge clk);
    n_chk++; if (rd_dat1 !== CLR1 || rd_val1 !== 1'b1) $display("FAIL busy_rd1 got %h/%b exp %h/1", rd_dat1, rd_val1, CLR1); else n_pass++;
  endtask

  task automatic test_reset_mid_clear;
    int n0, n1;
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    n0 = 0;
    for (int i = 0; i < 2000; i++) begin
      if (busy0) n0++;
      if (n0 >= 100) break;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (busy0 !== 1'b0) $display("FAIL abort_busy0 got %b exp 0", busy0); else n_pass++;
    n_chk++; if (busy1 !== 1'b0) $display("FAIL abort_busy1 got %b exp 0", busy1); else n_pass++;
    n_chk++; if (rd_val1 !== 1'b0) $display("FAIL abort_val1 got %b exp 0", rd_val1); else n_pass++;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    measure_busy(n0, n1);
    n_chk++; if (n0 != 256) $display("FAIL abort_len0 got %0d exp 256", n0); else n_pass++;
    n_chk++; if (n1 != 256) $display("FAIL abort_len1 got %0d exp 256", n1); else n_pass++;
    adr = 8'h20; rd_ena = 1'b1;
    @(negedge clk); rd_ena = 1'b0;
    n_chk++; if (rd_dat0 !== 32'h0 || rd_val0 !== 1'b1) $display("FAIL abort_rd0 got %h/%b exp 0/1", rd_dat0, rd_val0); else n_pass++;
    @(negedge clk);
    n_chk++; if (rd_dat1 !== CLR1 || rd_val1 !== 1'b1) $display("FAIL abort_rd1 got %h/%b exp %h/1", rd_dat1, rd_val1, CLR1); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_ena = 1'b0; rd_ena = 1'b0;
    adr = '0; msk = '0; wdat = '0;
    test_reset;
    test_clear_read;
    test_masked_write;
    test_back_to_back;
    test_wr_rd_collision;
    test_busy_ignore;
    test_reset_mid_clear;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
